// File: rtl/l2_gan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_gan_pkg
// Brief    : Shared word size, load length, bank address map and FSM
//            encoding for the l2_gan parameter loader.
// Revision : 1.0 - initial release
// ============================================================================
package l2_gan_pkg;

    localparam int WIDTH       = 16;
    localparam int TOTAL_WORDS = 73;

    // Bank address map: base word address and length in words per segment.
    localparam int L1_W_BASE = 0;   localparam int L1_W_LEN = 16;
    localparam int L1_B_BASE = 16;  localparam int L1_B_LEN = 4;
    localparam int L2_W_BASE = 20;  localparam int L2_W_LEN = 8;
    localparam int L2_B_BASE = 28;  localparam int L2_B_LEN = 2;
    localparam int L3_W_BASE = 30;  localparam int L3_W_LEN = 2;
    localparam int L3_B_BASE = 32;  localparam int L3_B_LEN = 1;
    localparam int L4_W_BASE = 33;  localparam int L4_W_LEN = 1;
    localparam int L4_B_BASE = 34;  localparam int L4_B_LEN = 1;
    localparam int L5_W_BASE = 35;  localparam int L5_W_LEN = 1;
    localparam int L5_B_BASE = 36;  localparam int L5_B_LEN = 1;
    localparam int L6_W_BASE = 37;  localparam int L6_W_LEN = 2;
    localparam int L6_B_BASE = 39;  localparam int L6_B_LEN = 2;
    localparam int L7_W_BASE = 41;  localparam int L7_W_LEN = 8;
    localparam int L7_B_BASE = 49;  localparam int L7_B_LEN = 4;
    localparam int L8_W_BASE = 53;  localparam int L8_W_LEN = 16;
    localparam int L8_B_BASE = 69;  localparam int L8_B_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : l2_gan_pkg
`default_nettype wire

// File: rtl/l2_gan_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : l2_gan_param_loader
// Brief    : Serial valid/ready loader filling the l2_gan weight/bias bank.
//            Optional checksum word: define L2_GAN_PARAM_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module l2_gan_param_loader
    import l2_gan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 params_valid,
    output logic [6:0]           word_cnt,
`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    output logic                 cksum_err,
`endif
    output logic [255:0]         L1_w,
    output logic [63:0]          L1_b,
    output logic [127:0]         L2_w,
    output logic [31:0]          L2_b,
    output logic [31:0]          L3_w,
    output logic [15:0]          L3_b,
    output logic [15:0]          L4_w,
    output logic [15:0]          L4_b,
    output logic [15:0]          L5_w,
    output logic [15:0]          L5_b,
    output logic [31:0]          L6_w,
    output logic [31:0]          L6_b,
    output logic [127:0]         L7_w,
    output logic [63:0]          L7_b,
    output logic [255:0]         L8_w,
    output logic [63:0]          L8_b
);

`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    localparam int LOAD_WORDS = TOTAL_WORDS + 1;
`else
    localparam int LOAD_WORDS = TOTAL_WORDS;
`endif

    state_t                        state_q, state_d;
    logic [6:0]                    cnt_q, cnt_d;
    logic [WIDTH-1:0]              bank_q [TOTAL_WORDS];
    logic [WIDTH*TOTAL_WORDS-1:0]  bank_flat;
    logic                          accept;

    // A start in LOAD restarts the load, so the word offered with it is dropped.
    assign accept = (state_q == ST_LOAD) && in_valid && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == 7'(LOAD_WORDS - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < TOTAL_WORDS; i++) begin : g_bank
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bank_q[i] <= '0;
            end else if (accept && (cnt_q == 7'(i))) begin
                bank_q[i] <= in_data;
            end
        end
        assign bank_flat[i*WIDTH +: WIDTH] = bank_q[i];
    end

`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             err_q, err_d;

    // Sum covers stored words only; the trailing checksum word is compared, not summed.
    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (start && (state_q != ST_LOAD || state_q == ST_LOAD)) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (accept) begin
            if (cnt_q < 7'(TOTAL_WORDS)) sum_d = sum_q + in_data;
            else                         err_d = ((sum_q + in_data) != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign cksum_err    = err_q;
    assign params_valid = (state_q == ST_DONE) && !err_q;
`else
    assign params_valid = (state_q == ST_DONE);
`endif

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q == ST_LOAD);
    assign word_cnt = cnt_q;

    assign L1_w = bank_flat[L1_W_BASE*WIDTH +: L1_W_LEN*WIDTH];
    assign L1_b = bank_flat[L1_B_BASE*WIDTH +: L1_B_LEN*WIDTH];
    assign L2_w = bank_flat[L2_W_BASE*WIDTH +: L2_W_LEN*WIDTH];
    assign L2_b = bank_flat[L2_B_BASE*WIDTH +: L2_B_LEN*WIDTH];
    assign L3_w = bank_flat[L3_W_BASE*WIDTH +: L3_W_LEN*WIDTH];
    assign L3_b = bank_flat[L3_B_BASE*WIDTH +: L3_B_LEN*WIDTH];
    assign L4_w = bank_flat[L4_W_BASE*WIDTH +: L4_W_LEN*WIDTH];
    assign L4_b = bank_flat[L4_B_BASE*WIDTH +: L4_B_LEN*WIDTH];
    assign L5_w = bank_flat[L5_W_BASE*WIDTH +: L5_W_LEN*WIDTH];
    assign L5_b = bank_flat[L5_B_BASE*WIDTH +: L5_B_LEN*WIDTH];
    assign L6_w = bank_flat[L6_W_BASE*WIDTH +: L6_W_LEN*WIDTH];
    assign L6_b = bank_flat[L6_B_BASE*WIDTH +: L6_B_LEN*WIDTH];
    assign L7_w = bank_flat[L7_W_BASE*WIDTH +: L7_W_LEN*WIDTH];
    assign L7_b = bank_flat[L7_B_BASE*WIDTH +: L7_B_LEN*WIDTH];
    assign L8_w = bank_flat[L8_W_BASE*WIDTH +: L8_W_LEN*WIDTH];
    assign L8_b = bank_flat[L8_B_BASE*WIDTH +: L8_B_LEN*WIDTH];

endmodule : l2_gan_param_loader
`default_nettype wire

// File: tb/tb_l2_gan_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_gan_param_loader
// Brief    : Directed self-checking bench for l2_gan_param_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_gan_param_loader;

`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    localparam int LOADLEN = 74;
`else
    localparam int LOADLEN = 73;
`endif
    localparam int NW = 73;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, busy, params_valid;
    logic [6:0] word_cnt;
`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    logic cksum_err;
`endif
    logic [255:0] L1_w, L8_w;
    logic [63:0]  L1_b, L7_b, L8_b;
    logic [127:0] L2_w, L7_w;
    logic [31:0]  L2_b, L3_w, L6_w, L6_b;
    logic [15:0]  L3_b, L4_w, L4_b, L5_w, L5_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] exp_bank [NW];
    logic [15:0] run_sum;

    always #5 clk = ~clk;

    l2_gan_param_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
        .params_valid(params_valid), .word_cnt(word_cnt),
`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
        .cksum_err(cksum_err),
`endif
        .L1_w(L1_w), .L1_b(L1_b), .L2_w(L2_w), .L2_b(L2_b),
        .L3_w(L3_w), .L3_b(L3_b), .L4_w(L4_w), .L4_b(L4_b),
        .L5_w(L5_w), .L5_b(L5_b), .L6_w(L6_w), .L6_b(L6_b),
        .L7_w(L7_w), .L7_b(L7_b), .L8_w(L8_w), .L8_b(L8_b)
    );

    // Segments are contiguous in address order, so the concatenation is the bank image.
    wire [NW*16-1:0] bus_all = {L8_b, L8_w, L7_b, L7_w, L6_b, L6_w, L5_b, L5_w,
                                L4_b, L4_w, L3_b, L3_w, L2_b, L2_w, L1_b, L1_w};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
        else pass_cnt++;
    endtask

    task automatic chk_bus(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < NW; i++)
            if (bad < 0 && bus_all[i*16 +: 16] !== exp_bank[i]) bad = i;
        total_cnt++;
        if (bad >= 0)
            $display("FAIL %s: word %0d got %h expected %h", name, bad,
                     bus_all[bad*16 +: 16], exp_bank[bad]);
        else pass_cnt++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 8) begin
            tick();
            k++;
        end
        if (in_ready) begin
            tick();
        end else begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1'b0;
    endtask

    // Stored word: updates the model and the running sum.
    task automatic send_stored(input int addr, input logic [15:0] d);
        send_word(d);
        exp_bank[addr] = d;
        run_sum = run_sum + d;
    endtask

    task automatic send_tail();
`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
        send_word(16'h0000 - run_sum);
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < NW; i++) exp_bank[i] = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_pv", 32'(params_valid), 0);
        chk("rst_cnt", 32'(word_cnt), 0);
        chk_bus("rst_bus");
        rst = 1'b0;
        tick();
        pulse_start();
        run_sum = '0;
        for (int a = 0; a < 10; a++) send_word(16'h0A00 + 16'(a));
        chk("midload_cnt", 32'(word_cnt), 10);
        chk("midload_L1w0", 32'(L1_w[15:0]), 32'h0A00);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", 32'(word_cnt), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_pv", 32'(params_valid), 0);
        chk("async_rst_ready", 32'(in_ready), 0);
        chk_bus("async_rst_bus");
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        pulse_start();
        chk("load_busy", 32'(busy), 1);
        chk("load_ready", 32'(in_ready), 1);
        chk("load_cnt0", 32'(word_cnt), 0);
        run_sum = '0;
        for (int a = 0; a < NW; a++) begin
            send_stored(a, 16'(a + 1));
            if (a == 0) chk("cnt_after_first", 32'(word_cnt), 1);
        end
        send_tail();
        chk("full_pv", 32'(params_valid), 1);
        chk("full_ready", 32'(in_ready), 0);
        chk("full_busy", 32'(busy), 0);
        chk("full_cnt", 32'(word_cnt), LOADLEN);
        chk("full_L1w0", 32'(L1_w[15:0]), 32'h0001);
        chk("full_L1b0", 32'(L1_b[15:0]), 32'h0011);
        chk("full_L3b", 32'(L3_b), 32'h0021);
        chk("full_L8b3", 32'(L8_b[63:48]), 32'h0049);
        chk("full_L4w", 32'(L4_w), 32'h0022);
        chk_bus("full_bus");
    endtask

    task automatic test_post_done();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            chk("done_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        chk("done_cnt", 32'(word_cnt), LOADLEN);
        chk("done_pv", 32'(params_valid), 1);
        chk_bus("done_bus");
    endtask

    task automatic test_restart();
        pulse_start();
        chk("restart_pv_clear", 32'(params_valid), 0);
        run_sum = '0;
        for (int a = 0; a < 40; a++) send_stored(a, 16'h7000 | 16'(a));
        chk("restart_cnt40", 32'(word_cnt), 40);
        chk_bus("restart_partial_bus");
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_cnt0", 32'(word_cnt), 0);
        chk("restart_busy", 32'(busy), 1);
        chk_bus("restart_no_accept_bus");
        run_sum = '0;
        for (int a = 0; a < NW; a++) begin
            chk("restart_pv_low", 32'(params_valid), 0);
            send_stored(a, 16'hFFFF);
        end
        send_tail();
        chk("restart_pv", 32'(params_valid), 1);
        chk("restart_L8w", 32'(L8_w[255:224]), 32'hFFFF_FFFF);
        chk_bus("restart_bus");
    endtask

    task automatic test_gapped();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) exp_bank[i] = '0;
        tick();
        pulse_start();
        run_sum = '0;
        for (int a = 0; a < NW; a++) begin
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            tick();
            chk("gap_cnt", 32'(word_cnt), a);
            send_stored(a, 16'(a + 1));
        end
        in_valid = 1'b0;
        tick();
        send_tail();
        chk("gap_final_cnt", 32'(word_cnt), LOADLEN);
        chk("gap_pv", 32'(params_valid), 1);
        chk_bus("gap_bus");
    endtask

`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
    task automatic test_cksum();
        pulse_start();
        for (int a = 0; a < NW; a++) send_word(16'h0001);
        chk("ck_good_pv_pre", 32'(params_valid), 0);
        send_word(16'hFFB7);
        chk("ck_good_pv", 32'(params_valid), 1);
        chk("ck_good_err", 32'(cksum_err), 0);
        chk("ck_good_L3b", 32'(L3_b), 32'h0001);
        pulse_start();
        for (int a = 0; a < NW; a++) send_word(16'h0001);
        send_word(16'h0000);
        chk("ck_bad_pv", 32'(params_valid), 0);
        chk("ck_bad_err", 32'(cksum_err), 1);
        chk("ck_bad_busy", 32'(busy), 0);
        pulse_start();
        chk("ck_err_clear", 32'(cksum_err), 0);
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_post_done();
        test_restart();
        test_gapped();
`ifdef L2_GAN_PARAM_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_l2_gan_param_loader
`default_nettype wire

// File: doc/l2_gan_param_loader.md
Name: l2_gan_param_loader

Overview:
- Upstream configuration stage for the l2_gan pipelined top.
- Accepts a serial stream of 16-bit signed parameter words over a valid/ready handshake and stores them in an internal register bank.
- Drives the flattened L1..L8 weight and bias buses that l2_gan consumes.
- Asserts params_valid once a complete, ordered parameter set has been captured.

Parameters:
- WIDTH, 16, bit width of each parameter word and bus slice.
- TOTAL_WORDS, 73, number of parameter words per load. Fixed by the network shape; taken from the package.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high. Single clock domain.
- start  in  1  one-cycle pulse; begins or restarts a load.
- in_data  in  WIDTH  signed parameter word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- busy  out  1  high while in LOAD.
- params_valid  out  1  a complete parameter set is held and the buses are stable.
- word_cnt  out  7  number of words accepted in the current load.
- L1_w / L1_b  out  256 / 64  layer 1 weights / biases.
- L2_w / L2_b  out  128 / 32  layer 2 weights / biases.
- L3_w / L3_b  out  32 / 16  layer 3 weights / biases.
- L4_w / L4_b  out  16 / 16  layer 4 weights / biases.
- L5_w / L5_b  out  16 / 16  layer 5 weights / biases.
- L6_w / L6_b  out  32 / 32  layer 6 weights / biases.
- L7_w / L7_b  out  128 / 64  layer 7 weights / biases.
- L8_w / L8_b  out  256 / 64  layer 8 weights / biases.

Behaviour:
- Reset values:
  - All register-bank words are 0, so every L*_w / L*_b bus reads 0.
  - word_cnt=0, busy=0, in_ready=0, params_valid=0, FSM in IDLE.
  - Reset asserted mid-load aborts the load immediately with the same result.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start -> LOAD with word_cnt cleared.
  - LOAD: in_ready=1. A word is accepted on the clk edge where in_valid&&in_ready, written to bank[word_cnt], and word_cnt increments. The accept that makes word_cnt=TOTAL_WORDS moves the FSM to DONE.
  - DONE: params_valid=1, in_ready=0. start -> LOAD.
- start during LOAD: restart. word_cnt -> 0; the bank is not cleared. A word presented in the same cycle as start is not accepted.
- Leaving DONE on start clears params_valid in the same edge. Buses keep their old values until overwritten word by word.
- Word order (bus slice i = bits [i*16 +: 16]; address:target):
  - 0-15 L1_w, 16-19 L1_b
  - 20-27 L2_w, 28-29 L2_b
  - 30-31 L3_w, 32 L3_b
  - 33 L4_w, 34 L4_b
  - 35 L5_w, 36 L5_b
  - 37-38 L6_w, 39-40 L6_b
  - 41-48 L7_w, 49-52 L7_b
  - 53-68 L8_w, 69-72 L8_b
- Buses are direct, unregistered slices of the bank; they change on the cycle after acceptance.
- in_valid in IDLE or DONE is ignored; words are not buffered.
- in_ready is a function of state only, never of in_valid.
- in_valid may be held high across cycles; one word is accepted per clock.

Optional Feature:
- Macro: L2_GAN_PARAM_LOADER_CKSUM_EN.
- Enabled:
  - The load is TOTAL_WORDS+1 words; word 73 is a checksum and is not stored.
  - Extra output cksum_err (1 bit), reset 0.
  - The loader keeps a modulo-2^16 running sum of words 0-72.
  - params_valid rises only if sum + word73 == 16'h0000. Otherwise the FSM goes to DONE with params_valid=0 and cksum_err=1.
  - cksum_err clears on start or rst.
- Disabled: 73-word load; no cksum_err port; no checksum logic.

Decomposition:
- Package l2_gan_pkg holds:
  - WIDTH and TOTAL_WORDS.
  - Per-segment base-address/length localparams (L1_W_BASE ... L8_B_BASE).
  - FSM state encoding.
- No sub-module needed. The bank is a single flat WIDTH*TOTAL_WORDS register with a generate-driven write decode.

Test Plan:
- Reset/idle: assert rst mid-LOAD after 10 words -> all buses 0, word_cnt=0, busy=0, params_valid=0.
- Full load: start, then words 0x0001..0x0049 back-to-back -> params_valid=1 one cycle after the 73rd accept; L1_w[15:0]=0x0001, L1_b[15:0]=0x0011, L3_b=0x0021, L8_b[63:48]=0x0049, in_ready=0.
- Gapped valid: toggle in_valid every other cycle -> exactly 73 accepts, same bus contents; words with in_valid=0 are not counted.
- Restart: start at word_cnt=40, then reload 73 words of 0xFFFF -> word_cnt restarts at 0; all slices end at 0xFFFF; params_valid low until completion.
- Post-done ignore: in DONE, drive in_valid with 0x1234 for 5 cycles -> buses unchanged, word_cnt=73.
- With CKSUM_EN: load 0x0001 x73 then 0xFFB7 -> params_valid=1. Load the same with last word 0x0000 -> cksum_err=1, params_valid=0.
